// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg: shared state enum and default geometry for the SLC-3 SRAM bridge
package slc3_mem_pkg;
  typedef enum logic {FILL, READY} state_t;
  localparam int DEPTH_LOG2_DEF = 10;
  localparam int INIT_LEN_DEF = 64;
endpackage

// File: rtl/slc3_init_rom.sv
// slc3_init_rom: combinational program image fed to the fill engine
//   addr  in   DEPTH_LOG2  word index (fill pointer)
//   data  out  16          image word, zero outside the listed program
module slc3_init_rom
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic [DEPTH_LOG2-1:0] addr,
  output logic [15:0]           data
);
  always_comb begin
    data = 16'h0000;
    case (int'(addr))
      0:  data = 16'h5020;
      1:  data = 16'h1025;
      2:  data = 16'h5260;
      3:  data = 16'h1261;
      4:  data = 16'h1240;
      5:  data = 16'h3002;
      6:  data = 16'h0FF9;
      7:  data = 16'hF025;
      63: data = 16'hC1C0;
      default: data = 16'h0000;
    endcase
  end
endmodule

// File: rtl/slc3_sram_bridge.sv
// slc3_sram_bridge: on-chip word RAM for SLC-3 with zero-fill/program-load engine
//   Clk             in   1   system clock
//   Reset           in   1   asynchronous active-low reset
//   ADDR            in   16  word address
//   Data_to_SRAM    in   16  write data
//   OE, WE          in   1   active-low read / write strobes
//   Reload          in   1   one-cycle pulse restarting the fill
//   Data_from_SRAM  out  16  registered read data
//   Init_done       out  1   fill finished, CPU accesses honoured
//   Err_oob         out  1   sticky out-of-range access flag
module slc3_sram_bridge
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int INIT_LEN   = INIT_LEN_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_to_SRAM,
  input  logic        OE,
  input  logic        WE,
  input  logic        Reload,
  output logic [15:0] Data_from_SRAM,
  output logic        Init_done,
  output logic        Err_oob
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEN = (DEPTH_LOG2 + 1)'(INIT_LEN);
  generate
    if (INIT_LEN > DEPTH) begin : g_len_chk
      $error("INIT_LEN exceeds RAM depth");
    end
  endgenerate
  state_t state, state_nx;
  logic [DEPTH_LOG2-1:0] fill_ptr, wa;
  logic [15:0] mem [DEPTH];
  logic [15:0] rom_data, wd;
  logic cpu, in_range, cpu_we, cpu_re, we;
  slc3_init_rom #(.DEPTH_LOG2(DEPTH_LOG2)) u_rom (
    .addr(fill_ptr),
    .data(rom_data)
  );
  // A Reload cycle drops any coincident CPU access.
  always_comb begin
    cpu = state == READY && !Reload;
    in_range = (ADDR >> DEPTH_LOG2) == 16'h0000;
    cpu_we = cpu && !WE && in_range;
    cpu_re = cpu && !OE && WE;
    we = state == FILL || cpu_we;
    wa = state == FILL ? fill_ptr : ADDR[DEPTH_LOG2-1:0];
    wd = state == FILL ? ({1'b0, fill_ptr} < LEN ? rom_data : 16'h0000) : Data_to_SRAM;
    state_nx = Reload ? FILL : (state == FILL && fill_ptr == '1) ? READY : state;
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= FILL;
    else state <= state_nx;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      fill_ptr <= '0;
      Init_done <= 1'b0;
      Data_from_SRAM <= 16'h0000;
      Err_oob <= 1'b0;
    end else begin
      fill_ptr <= Reload ? '0 : state == FILL ? fill_ptr + 1'b1 : fill_ptr;
      Init_done <= state_nx == READY;
      Data_from_SRAM <= !cpu ? 16'h0000 : cpu_re ? (in_range ? mem[ADDR[DEPTH_LOG2-1:0]] : 16'h0000) : Data_from_SRAM;
      Err_oob <= Err_oob || (cpu && (!OE || !WE) && !in_range);
    end
  always_ff @(posedge Clk)
    if (we) mem[wa] <= wd;
endmodule

// File: tb/tb_slc3_sram_bridge.sv
// tb_slc3_sram_bridge: vector table plus multi-cycle fill/reload/reset sequences
module tb_slc3_sram_bridge;
  import slc3_mem_pkg::*;
  localparam logic [15:0] ROM0 = 16'h5020;
  localparam logic [15:0] ROM1 = 16'h1025;
  localparam logic [15:0] ROM5 = 16'h3002;
  localparam logic [15:0] ROM63 = 16'hC1C0;
  typedef struct {
    logic oe;
    logic we;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic exp_err;
  } vec_t;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic [15:0] Data_to_SRAM = 16'h0000;
  logic OE = 1'b1;
  logic WE = 1'b1;
  logic Reload = 1'b0;
  logic [15:0] Data_from_SRAM;
  logic Init_done;
  logic Err_oob;
  int total = 0;
  int bad = 0;
  logic [15:0] sb [$];
  vec_t vecs [16];
  slc3_sram_bridge dut (
    .Clk(Clk),
    .Reset(Reset),
    .ADDR(ADDR),
    .Data_to_SRAM(Data_to_SRAM),
    .OE(OE),
    .WE(WE),
    .Reload(Reload),
    .Data_from_SRAM(Data_from_SRAM),
    .Init_done(Init_done),
    .Err_oob(Err_oob)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic drive(input logic oe, input logic we, input logic [15:0] a, input logic [15:0] d);
    OE = oe;
    WE = we;
    ADDR = a;
    Data_to_SRAM = d;
  endtask
  task automatic sb_check(input string name);
    logic [15:0] e;
    if (sb.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(name, {16'h0, Data_from_SRAM}, {16'h0, e});
    end
  endtask
  task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
    drive(1'b0, 1'b1, a, 16'h0000);
    sb.push_back(exp);
    step();
    sb_check(name);
    drive(1'b1, 1'b1, 16'h0000, 16'h0000);
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, 1'b0, a, d);
    step();
    drive(1'b1, 1'b1, 16'h0000, 16'h0000);
  endtask
  task automatic wait_ready(output int cnt, output bit dout_nz);
    cnt = 0;
    dout_nz = 0;
    while (!Init_done && cnt < 3000) begin
      step();
      cnt++;
      if (!Init_done && Data_from_SRAM != 16'h0000) dout_nz = 1;
    end
  endtask
  initial begin
    int cnt;
    bit nz;
    vecs[0]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, ROM0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0001, 16'h0000, ROM1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'h003F, 16'h0000, ROM63, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'h0005, 16'h0000, ROM5, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'h0005, 16'h1234, ROM5, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'h0005, 16'h0000, 16'h1234, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 16'h0009, 16'h4444, 16'h1234, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0007, 16'hBEEF, 16'h1234, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 16'h0007, 16'h0000, 16'hBEEF, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'h03FF, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h03FF, 16'hCAFE, 16'h0000, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'h03FF, 16'h0000, 16'hCAFE, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 16'h0400, 16'h5555, 16'h0000, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 16'h0000, 16'h0000, ROM0, 1'b1};
    repeat (3) step();
    check("reset dout", {16'h0, Data_from_SRAM}, 32'h0);
    check("reset init_done", {31'h0, Init_done}, 32'h0);
    check("reset err", {31'h0, Err_oob}, 32'h0);
    Reset = 1'b1;
    drive(1'b1, 1'b0, 16'h0005, 16'h7777);
    wait_ready(cnt, nz);
    drive(1'b1, 1'b1, 16'h0000, 16'h0000);
    check("fill cycles", cnt, 32'd1024);
    check("dout zero during fill", {31'h0, nz}, 32'h0);
    check("err after fill", {31'h0, Err_oob}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].oe, vecs[i].we, vecs[i].addr, vecs[i].din);
      sb.push_back(vecs[i].exp_dout);
      step();
      sb_check($sformatf("vec%0d dout", i));
      check($sformatf("vec%0d err", i), {31'h0, Err_oob}, {31'h0, vecs[i].exp_err});
    end
    drive(1'b1, 1'b1, 16'h0000, 16'h0000);
    step();
    check("err sticky idle", {31'h0, Err_oob}, 32'h1);
    wr(16'h0000, 16'hAAAA);
    rd("read aaaa", 16'h0000, 16'hAAAA);
    Reload = 1'b1;
    step();
    Reload = 1'b0;
    check("reload init_done", {31'h0, Init_done}, 32'h0);
    check("reload dout", {16'h0, Data_from_SRAM}, 32'h0);
    check("reload err kept", {31'h0, Err_oob}, 32'h1);
    repeat (100) step();
    Reload = 1'b1;
    step();
    Reload = 1'b0;
    wait_ready(cnt, nz);
    check("refill cycles", cnt, 32'd1024);
    rd("reload addr0", 16'h0000, ROM0);
    rd("reload addr5", 16'h0005, ROM5);
    rd("reload addr3ff", 16'h03FF, 16'h0000);
    check("err after reload", {31'h0, Err_oob}, 32'h1);
    Reload = 1'b1;
    step();
    Reload = 1'b0;
    repeat (300) step();
    Reset = 1'b0;
    #1;
    check("async reset dout", {16'h0, Data_from_SRAM}, 32'h0);
    check("async reset err", {31'h0, Err_oob}, 32'h0);
    check("async reset init_done", {31'h0, Init_done}, 32'h0);
    repeat (2) step();
    Reset = 1'b1;
    wait_ready(cnt, nz);
    check("post reset fill cycles", cnt, 32'd1024);
    rd("post reset addr0", 16'h0000, ROM0);
    rd("post reset addr63", 16'h003F, ROM63);
    check("scoreboard drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
